// File: rtl/fixed_frame_gen_pkg.sv
// rtl/fixed_frame_gen_pkg.sv - shared types and constants for the fixed-pattern frame generator
// Contents: pattern mode encodings, FSM state enum, default sync word, PRBS-15 seed and step function.
package fixed_frame_gen_pkg;

   localparam logic [1:0] MODE_INC   = 2'd0;
   localparam logic [1:0] MODE_WALK  = 2'd1;
   localparam logic [1:0] MODE_PRBS  = 2'd2;
   localparam logic [1:0] MODE_CONST = 2'd3;

   localparam logic [15:0] HDR_WORD_DEF = 16'hEB90;
   localparam logic [15:0] CONST_WORD   = 16'hA5A5;
   localparam logic [14:0] PRBS_SEED    = 15'h7FFF;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      CNT,
      PAY,
      GAP
   } state_t;

   // x^15 + x^14 + 1, shifting towards the MSB so the seed walks 7FFF, 7FFE, 7FFC, ...
   function automatic logic [14:0] prbs15_next(input logic [14:0] s);
      return {s[13:0], s[14] ^ s[13]};
   endfunction

endpackage

// File: rtl/prbs15_gen.sv
// rtl/prbs15_gen.sv - PRBS-15 generator with load and step controls
// Ports: clk, reset (sync, active-high); load reseeds to PRBS_SEED and wins over step;
//        step advances one state; q is the current 15-bit state.
module prbs15_gen
   import fixed_frame_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   output logic [14:0] q
);

   always_ff @(posedge clk) begin
      if (reset || load) begin
         q <= PRBS_SEED;
      end else if (step) begin
         q <= prbs15_next(q);
      end
   end

endmodule

// File: rtl/fixed_frame_gen.sv
// rtl/fixed_frame_gen.sv - framed 16-bit test-pattern source for the channel selector
// Ports: clk, reset (sync, active-high); fixed_oe run grant; mode pattern select;
//        rate_div word pacing (one word per rate_div+1 cycles); full downstream almost-full;
//        fixed_db/fixed_wren registered data and write strobe; frame_cnt completed frames;
//        busy high outside IDLE.
module fixed_frame_gen
   import fixed_frame_gen_pkg::*;
#(
   parameter int              DATA_W    = 16,
   parameter int              FRAME_LEN = 256,
   parameter logic [15:0]     HDR_WORD  = HDR_WORD_DEF,
   parameter int              GAP_CYC   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fixed_oe,
   input  logic [1:0]        mode,
   input  logic [7:0]        rate_div,
   input  logic              full,
   output logic [DATA_W-1:0] fixed_db,
   output logic              fixed_wren,
   output logic [15:0]       frame_cnt,
   output logic              busy
);

   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

   state_t      state, state_nxt;
   logic [7:0]  div_cnt;
   logic [15:0] idx;
   logic [15:0] gap_cnt;
   logic [1:0]  mode_q;
   logic [14:0] lfsr_q;
   logic        running;
   logic        eligible;
   logic        emit;
   logic        last_pay;
   logic        enter_hdr;
   logic [15:0] pay_word;
   logic [15:0] word;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A grant drop during HDR/CNT/PAY aborts before any emission check, so the abort always
   // wins over an emission-eligible cycle.
   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      running   = (state == HDR) || (state == CNT) || (state == PAY);
      eligible  = (div_cnt >= rate_div) && !full;
      last_pay  = (state == PAY) && (idx == LAST_IDX);
      unique case (state)
         IDLE: if (fixed_oe) state_nxt = HDR;
         HDR: begin
            if (!fixed_oe) begin
               state_nxt = IDLE;
            end else if (eligible) begin
               emit      = 1'b1;
               state_nxt = CNT;
            end
         end
         CNT: begin
            if (!fixed_oe) begin
               state_nxt = IDLE;
            end else if (eligible) begin
               emit      = 1'b1;
               state_nxt = PAY;
            end
         end
         PAY: begin
            if (!fixed_oe) begin
               state_nxt = IDLE;
            end else if (eligible) begin
               emit = 1'b1;
               if (last_pay) state_nxt = (GAP_CYC == 0) ? HDR : GAP;
            end
         end
         GAP: if (gap_cnt == GAP_LAST) state_nxt = fixed_oe ? HDR : IDLE;
         default: state_nxt = IDLE;
      endcase
      enter_hdr = (state_nxt == HDR) && (state != HDR);
   end

   always_comb begin
      pay_word = CONST_WORD;
      unique case (mode_q)
         MODE_INC:   pay_word = idx;
         MODE_WALK:  pay_word = 16'h0001 << idx[3:0];
         MODE_PRBS:  pay_word = {1'b0, lfsr_q};
         MODE_CONST: pay_word = CONST_WORD;
         default:    pay_word = CONST_WORD;
      endcase
      word = pay_word;
      if (state == HDR) word = HDR_WORD;
      else if (state == CNT) word = frame_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fixed_db   <= '0;
         fixed_wren <= 1'b0;
         frame_cnt  <= '0;
         div_cnt    <= '0;
         idx        <= '0;
         gap_cnt    <= '0;
         mode_q     <= MODE_INC;
      end else begin
         fixed_wren <= emit;
         if (emit) fixed_db <= word;

         // Saturating divider keeps counting through a stall, so a released stall emits at once.
         if (enter_hdr || emit) begin
            div_cnt <= '0;
         end else if (running && (div_cnt < rate_div)) begin
            div_cnt <= div_cnt + 8'd1;
         end

         if (enter_hdr) begin
            idx <= '0;
         end else if (emit && (state == PAY)) begin
            idx <= last_pay ? 16'd0 : idx + 16'd1;
         end

         if (emit && last_pay) frame_cnt <= frame_cnt + 16'd1;

         gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;

         if (enter_hdr) mode_q <= mode;
      end
   end

   prbs15_gen u_prbs (
      .clk   (clk),
      .reset (reset),
      .load  (enter_hdr),
      .step  (emit && (state == PAY)),
      .q     (lfsr_q)
   );

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_fixed_frame_gen.sv
// tb/tb_fixed_frame_gen.sv - self-checking bench for fixed_frame_gen
module tb_fixed_frame_gen;

   localparam int FL = 8;
   localparam int GC = 4;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        fixed_oe = 1'b0;
   logic        full     = 1'b0;
   logic [1:0]  mode     = 2'd0;
   logic [7:0]  rate_div = 8'd0;
   logic [15:0] fixed_db;
   logic        fixed_wren;
   logic [15:0] frame_cnt;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int viol  = 0;
   int mfc   = 0;
   int chk_i = 0;
   logic [15:0] obs_q[$];
   int          obs_cyc[$];
   logic [15:0] exp_q[$];
   logic        full_s, oe_s;

   fixed_frame_gen #(.DATA_W(16), .FRAME_LEN(FL), .HDR_WORD(16'hEB90), .GAP_CYC(GC)) dut (
      .clk        (clk),
      .reset      (reset),
      .fixed_oe   (fixed_oe),
      .mode       (mode),
      .rate_div   (rate_div),
      .full       (full),
      .fixed_db   (fixed_db),
      .fixed_wren (fixed_wren),
      .frame_cnt  (frame_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Word monitor: samples #1 after the edge, remembers the inputs seen at that edge.
   always @(posedge clk) begin
      full_s = full;
      oe_s   = fixed_oe;
      #1;
      if (fixed_wren) begin
         obs_q.push_back(fixed_db);
         obs_cyc.push_back(cyc);
         if (full_s || !oe_s) viol++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] prbs_word(input int n);
      logic [14:0] s;
      s = 15'h7FFF;
      for (int k = 0; k < n; k++) s = {s[13:0], s[14] ^ s[13]};
      return {1'b0, s};
   endfunction

   function automatic logic [15:0] model_pay(input int md, input int i);
      case (md)
         0:       return 16'(i);
         1:       return 16'(1 << (i % 16));
         2:       return prbs_word(i);
         default: return 16'hA5A5;
      endcase
   endfunction

   // Expected words for one frame (or its first npay payload words if cut short).
   task automatic push_frame(input int md, input int npay);
      exp_q.push_back(16'hEB90);
      exp_q.push_back(16'(mfc));
      for (int i = 0; i < npay; i++) exp_q.push_back(model_pay(md, i));
      if (npay == FL) mfc = (mfc + 1) % 65536;
   endtask

   task automatic compare_words();
      if (obs_q.size() < exp_q.size()) begin
         check("word_count", 32'(obs_q.size()), 32'(exp_q.size()));
      end
      while (chk_i < exp_q.size() && chk_i < obs_q.size()) begin
         check($sformatf("word%0d", chk_i), 32'(obs_q[chk_i]), 32'(exp_q[chk_i]));
         chk_i++;
      end
      chk_i = exp_q.size();
   endtask

   task automatic wait_words(input int n);
      int b;
      b = 0;
      while (obs_q.size() < n && b < 600) begin
         @(negedge clk);
         b++;
      end
      if (obs_q.size() < n) check("wait_timeout", 32'(obs_q.size()), 32'(n));
   endtask

   initial begin
      int c0, base, rel, md, b;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_db", 32'(fixed_db), 32'h0);
      check("rst_wren", 32'(fixed_wren), 32'h0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'h0);

      // Incrementing, back-to-back at full rate, latency and gap
      c0 = cyc;
      fixed_oe = 1'b1;
      wait_words(10);
      check("frame_cnt_after_1", 32'(frame_cnt), 32'd1);
      wait_words(20);
      fixed_oe = 1'b0;
      check("latency", 32'(obs_cyc[0]), 32'(c0 + 2));
      for (int i = 1; i < 20; i++)
         check($sformatf("spacing%0d", i), 32'(obs_cyc[i] - obs_cyc[i-1]), (i == 10) ? 32'(GC + 1) : 32'd1);
      check("frame_cnt_after_2", 32'(frame_cnt), 32'd2);
      push_frame(0, FL);
      push_frame(0, FL);
      compare_words();
      repeat (12) @(negedge clk);
      check("gap_drop_no_words", 32'(obs_q.size()), 32'd20);
      check("gap_drop_busy", 32'(busy), 32'h0);

      // Paced, random mode
      md = int'($urandom_range(3));
      mode = 2'(md);
      rate_div = 8'd3;
      base = obs_q.size();
      fixed_oe = 1'b1;
      wait_words(base + 10);
      fixed_oe = 1'b0;
      for (int i = base + 1; i < base + 10; i++)
         check($sformatf("paced%0d", i), 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd4);
      push_frame(md, FL);
      compare_words();
      repeat (12) @(negedge clk);

      // PRBS with a 5-cycle stall after the third payload word
      mode = 2'd2;
      rate_div = 8'd0;
      base = obs_q.size();
      fixed_oe = 1'b1;
      wait_words(base + 5);
      full = 1'b1;
      repeat (5) @(negedge clk);
      check("stall_no_words", 32'(obs_q.size()), 32'(base + 5));
      rel = cyc;
      full = 1'b0;
      wait_words(base + 20);
      fixed_oe = 1'b0;
      check("stall_resume", 32'(obs_cyc[base + 5]), 32'(rel + 1));
      check("prbs0", 32'(obs_q[base + 2]), 32'h7FFF);
      check("prbs1", 32'(obs_q[base + 3]), 32'h7FFE);
      check("prbs2", 32'(obs_q[base + 4]), 32'h7FFC);
      check("prbs3", 32'(obs_q[base + 5]), 32'h7FF8);
      check("prbs_restart", 32'(obs_q[base + 12]), 32'h7FFF);
      push_frame(2, FL);
      push_frame(2, FL);
      compare_words();
      repeat (12) @(negedge clk);

      // Abort after five payload words, then re-grant
      mode = 2'd0;
      base = obs_q.size();
      fixed_oe = 1'b1;
      wait_words(base + 7);
      fixed_oe = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_no_words", 32'(obs_q.size()), 32'(base + 7));
      check("abort_frame_cnt", 32'(frame_cnt), 32'(mfc));
      check("abort_busy", 32'(busy), 32'h0);
      push_frame(0, 5);
      fixed_oe = 1'b1;
      wait_words(base + 17);
      fixed_oe = 1'b0;
      push_frame(0, FL);
      compare_words();
      repeat (12) @(negedge clk);

      // Random mode, rate and backpressure; mode wiggled mid-frame
      for (int r = 0; r < 4; r++) begin
         md = int'($urandom_range(3));
         mode = 2'(md);
         rate_div = 8'($urandom_range(2));
         base = obs_q.size();
         fixed_oe = 1'b1;
         b = 0;
         while (obs_q.size() < base + 10 && b < 1000) begin
            @(negedge clk);
            full = ($urandom_range(3) == 0);
            if (obs_q.size() > base) mode = 2'($urandom_range(3));
            b++;
         end
         full = 1'b0;
         fixed_oe = 1'b0;
         if (obs_q.size() < base + 10) check("rand_timeout", 32'(obs_q.size()), 32'(base + 10));
         push_frame(md, FL);
         compare_words();
         repeat (12) @(negedge clk);
      end

      // Reset mid-payload
      mode = 2'd0;
      rate_div = 8'd0;
      base = obs_q.size();
      fixed_oe = 1'b1;
      wait_words(base + 5);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_db", 32'(fixed_db), 32'h0);
      check("midrst_wren", 32'(fixed_wren), 32'h0);
      check("midrst_frame_cnt", 32'(frame_cnt), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      push_frame(0, 3);
      mfc = 0;
      wait_words(base + 15);
      fixed_oe = 1'b0;
      push_frame(0, FL);
      compare_words();
      repeat (12) @(negedge clk);

      check("strobe_while_full_or_ungranted", 32'(viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fixed_frame_gen.md
Name: fixed_frame_gen

Overview:
- Upstream "fixed" data source for the channel selector. Produces framed 16-bit test-pattern words on fixed_db/fixed_wren.
- Runs only while the selector grants it via fixed_oe. Paced by a programmable rate divider and stalled by downstream almost-full backpressure.
- Used for link and SSD-path bring-up without RAM or SSD traffic.

Parameters:
- DATA_W, 16, word width; only 16 is supported.
- FRAME_LEN, 256, payload words per frame; range 1..65535.
- HDR_WORD, 16'hEB90, sync word emitted first in every frame.
- GAP_CYC, 4, idle cycles between frames; 0 means back-to-back frames.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fixed_oe  in  1  grant from the channel selector; 1 means run.
- mode  in  2  pattern select: 0 incrementing, 1 walking-one, 2 PRBS-15, 3 constant 16'hA5A5.
- rate_div  in  8  emit one word every rate_div+1 cycles; 0 means every cycle.
- full  in  1  downstream almost-full; 1 stalls emission.
- fixed_db  out  16  data word, registered.
- fixed_wren  out  1  single-cycle write strobe qualifying fixed_db, registered.
- frame_cnt  out  16  count of completed frames.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high, one clock) forces all of the following. This also applies mid-frame, where it aborts immediately with no further strobes.
  - State IDLE.
  - fixed_db=0, fixed_wren=0, frame_cnt=0, busy=0.
  - div_cnt=0, payload index=0, LFSR=15'h7FFF.
- States:
  - IDLE -> HDR when fixed_oe=1.
  - HDR -> CNT after the header word is emitted.
  - CNT -> PAY after the counter word is emitted.
  - PAY -> GAP after payload word FRAME_LEN-1 is emitted (straight to HDR/IDLE when GAP_CYC=0).
  - GAP -> HDR after GAP_CYC cycles if fixed_oe=1, otherwise -> IDLE.
- Frame layout: HDR_WORD, then frame_cnt (value before increment), then FRAME_LEN payload words.
- mode is sampled on entry to HDR and held for the whole frame. Changing mode mid-frame has no effect until the next frame.
- Pacing:
  - div_cnt is cleared to 0 on entry to HDR.
  - In HDR, CNT and PAY, div_cnt increments each cycle and saturates at rate_div.
  - A word is emitted in a cycle where div_cnt==rate_div and full==0. In that cycle fixed_wren=1 and fixed_db=word are registered, and div_cnt is cleared to 0.
  - In all other cycles fixed_wren=0 and fixed_db holds its last value.
- full: while full=1, no emission, and neither state nor index advances. Emission resumes on the first cycle full=0 with div_cnt already saturated, so a stall adds no extra divider delay.
- Latency: with rate_div=0 and full=0, if fixed_oe=1 is sampled at edge k, the HDR word appears with fixed_wren=1 after edge k+1. Subsequent words follow on consecutive cycles.
- Payload for index i (0..FRAME_LEN-1):
  - Incrementing: i[15:0].
  - Walking-one: 16'h0001 << (i mod 16).
  - PRBS-15: {1'b0, lfsr}. The LFSR uses x^15+x^14+1, is seeded to 15'h7FFF on HDR entry, and advances after each emitted payload word. The first payload word is 16'h7FFF.
  - Constant: 16'hA5A5.
- frame_cnt increments in the cycle the last payload word is emitted and wraps from 16'hFFFF to 0.
- fixed_oe deasserted in HDR, CNT or PAY: abort. Go to IDLE on the next edge with no strobe that cycle; frame_cnt is not incremented. The next grant starts a fresh frame from HDR.
- fixed_oe deasserted in GAP: finish the gap, then go to IDLE.
- Simultaneous fixed_oe falling edge and an emission-eligible cycle: the abort wins and no strobe is produced.
- fixed_oe re-asserted in IDLE and sampled the same cycle: transition to HDR with normal latency.

Decomposition:
- Shared package holds:
  - mode encodings: MODE_INC=0, MODE_WALK=1, MODE_PRBS=2, MODE_CONST=3.
  - the state enum: IDLE, HDR, CNT, PAY, GAP.
  - constants HDR_WORD_DEF and PRBS_SEED.
- One sub-module, prbs15_gen, with ports clk, reset, load, step and q[14:0]. It is reusable by the SSD checker path.
- The rest (FSM, divider, index/frame counters) stays in this module.

Test Plan:
- Incrementing, bursty: FRAME_LEN=8, rate_div=0, full=0, mode=0, fixed_oe held 1 -> wren bursts of 10 words: EB90, 0000, 0000..0007. Then 4 idle cycles, then EB90, 0001, 0000.. ; frame_cnt=1 after the first frame.
- Paced: rate_div=3 -> exactly 3 idle cycles between consecutive wren pulses within a frame.
- PRBS-15: mode=2 -> first payload words 7FFF, 7FFE, 7FFC, 7FF8; pattern restarts at 7FFF in each frame.
- Backpressure: full=1 for 5 cycles after the 3rd payload word -> no wren during the stall. The 4th word appears on the first cycle full=0, with no duplicated or skipped words.
- Abort: fixed_oe dropped after 5 payload words -> wren=0 from the next cycle, frame_cnt unchanged. On re-grant the next frame starts at EB90 with the same frame_cnt value.
- Reset: reset pulsed mid-payload -> all outputs 0 next cycle, frame_cnt=0, and the next frame begins with EB90, 0000.
